// File: rtl/fpdiv_round_pack.sv
// Final stage of the single-precision divider: normalizes, denormalizes, rounds to
// nearest-even and packs the quotient into IEEE-754 format, with a valid/ready handshake.
module fpdiv_round_pack (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic        IN_SIGN,
  input  logic [9:0]  IN_EXP,
  input  logic [25:0] IN_MANT,
  input  logic        IN_STICKY,
  input  logic [1:0]  IN_SPECIAL,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [31:0] OUT_RESULT,
  output logic [1:0]  OUT_EXCEPTION
);

  localparam int unsigned EXP_W  = 11;
  localparam int unsigned MANT_W = 26;
  localparam int unsigned SIG_W  = 24;
  localparam int unsigned RES_W  = 32;

  localparam logic signed [EXP_W-1:0] EXP_MIN   = -11'sd126;
  localparam logic signed [EXP_W-1:0] EXP_FLUSH = -11'sd152;
  localparam logic signed [EXP_W-1:0] EXP_MAX   = 11'sd127;
  localparam logic signed [EXP_W-1:0] EXP_BIAS  = 11'sd127;

  localparam logic [1:0] EXC_NONE      = 2'b00;
  localparam logic [1:0] EXC_UNDERFLOW = 2'b01;
  localparam logic [1:0] EXC_OVERFLOW  = 2'b10;
  localparam logic [1:0] EXC_INVALID   = 2'b11;

  typedef enum logic [2:0] {IDLE, NORM, DENORM, ROUND, DONE} state_t;

  state_t                   state_q, state_d;
  logic                     sign_q, sign_d;
  logic signed [EXP_W-1:0]  exp_q, exp_d;
  logic [MANT_W-1:0]        mant_q, mant_d;
  logic                     sticky_q, sticky_d;
  logic [RES_W-1:0]         result_d;
  logic [1:0]               exc_d;

  logic                     round_inc;
  logic [SIG_W:0]           round_sum;
  logic [SIG_W-1:0]         r_sig;
  logic signed [EXP_W-1:0]  r_exp;
  logic                     inexact;
  logic [7:0]               exp_field;

  // Round-to-nearest-even on bits 25:2, renormalizing on carry-out.
  always_comb begin
    round_inc = mant_q[1] & (mant_q[0] | sticky_q | mant_q[2]);
    round_sum = {1'b0, mant_q[MANT_W-1:2]} + (SIG_W+1)'(round_inc);
    r_sig     = round_sum[SIG_W-1:0];
    r_exp     = exp_q;
    if (round_sum[SIG_W]) begin
      r_sig = round_sum[SIG_W:1];
      r_exp = exp_q + 11'sd1;
    end
    inexact   = mant_q[1] | mant_q[0] | sticky_q;
    exp_field = 8'(r_exp + EXP_BIAS);
  end

  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    mant_d   = mant_q;
    sticky_d = sticky_q;
    result_d = OUT_RESULT;
    exc_d    = OUT_EXCEPTION;
    case (state_q)
      IDLE: begin
        if (IN_VALID) begin
          sign_d   = IN_SIGN;
          exp_d    = {IN_EXP[9], IN_EXP};
          mant_d   = IN_MANT;
          sticky_d = IN_STICKY;
          case (IN_SPECIAL)
            2'b00: state_d = NORM;
            2'b01: begin
              result_d = {IN_SIGN, 31'h0};
              exc_d    = EXC_NONE;
              state_d  = DONE;
            end
            2'b10: begin
              result_d = {IN_SIGN, 8'hFF, 23'h0};
              exc_d    = EXC_NONE;
              state_d  = DONE;
            end
            default: begin
              result_d = 32'h7FFF_FFFF;
              exc_d    = EXC_INVALID;
              state_d  = DONE;
            end
          endcase
        end
      end
      NORM: begin
        if (mant_q == '0) begin
          result_d = {sign_q, 31'h0};
          exc_d    = EXC_NONE;
          state_d  = DONE;
        end else if (!mant_q[MANT_W-1]) begin
          mant_d = mant_q << 1;
          exp_d  = exp_q - 11'sd1;
        end else begin
          state_d = DENORM;
        end
      end
      DENORM: begin
        // Far below the subnormal range everything collapses into sticky at once.
        if (exp_q < EXP_FLUSH) begin
          mant_d   = '0;
          sticky_d = sticky_q | (|mant_q);
          exp_d    = EXP_MIN;
        end else if (exp_q < EXP_MIN) begin
          mant_d   = mant_q >> 1;
          sticky_d = sticky_q | mant_q[0];
          exp_d    = exp_q + 11'sd1;
        end else begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        state_d = DONE;
        if (r_exp > EXP_MAX) begin
          result_d = {sign_q, 8'hFF, 23'h0};
          exc_d    = EXC_OVERFLOW;
        end else if (r_sig[SIG_W-1]) begin
          result_d = {sign_q, exp_field, r_sig[SIG_W-2:0]};
          exc_d    = EXC_NONE;
        end else begin
          result_d = {sign_q, 8'h00, r_sig[SIG_W-2:0]};
          exc_d    = inexact ? EXC_UNDERFLOW : EXC_NONE;
        end
      end
      DONE: begin
        if (OUT_READY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q       <= IDLE;
      sign_q        <= 1'b0;
      exp_q         <= '0;
      mant_q        <= '0;
      sticky_q      <= 1'b0;
      IN_READY      <= 1'b1;
      OUT_VALID     <= 1'b0;
      OUT_RESULT    <= '0;
      OUT_EXCEPTION <= EXC_NONE;
    end else begin
      state_q       <= state_d;
      sign_q        <= sign_d;
      exp_q         <= exp_d;
      mant_q        <= mant_d;
      sticky_q      <= sticky_d;
      IN_READY      <= (state_d == IDLE);
      OUT_VALID     <= (state_d == DONE);
      OUT_RESULT    <= result_d;
      OUT_EXCEPTION <= exc_d;
    end
  end

endmodule
